mult_bcd_scheduler: RTL and testbench
=====================================

# mult_bcd_scheduler

Sequencing and sharing controller for the team's combinational N-bit multiplier feeding a seven-segment/BCD display path. Two requesters compete for one multiplier instance. The block arbitrates, drives the shared multiplier with the winner's operands and captures the product. It then converts the product to packed BCD with a sequential shift-add-3 (double dabble) engine and presents binary and BCD results on a valid/ready output port.

## Interface
- `WIDTH`, 4, operand width of the multiplier; product is 2*WIDTH bits.
- `BCD_DIGITS`, 3, number of BCD digits on `out_bcd`; must satisfy 10^BCD_DIGITS > (2^WIDTH-1)^2.

Clocking and reset: one clock; reset is asynchronous and active-low. Ports are `clk` and `rst_n`.

- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0_valid`  in  1  requester 0 has operands pending.
- `req0_m`, `req0_q`  in  WIDTH  requester 0 multiplicand/multiplier.
- `req0_ready`  out  1  requester 0 granted; transfer on valid&ready.
- `req1_valid`, `req1_m`, `req1_q`, `req1_ready`  same as above for requester 1.
- `mult_m`, `mult_q`  out  WIDTH  operands to the shared multiplier (registered).
- `mult_p`  in  2*WIDTH  product returned by the shared multiplier (combinational).
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts result.
- `out_bin`  out  2*WIDTH  binary product.
- `out_bcd`  out  4*BCD_DIGITS  packed BCD product, digit 0 in bits [3:0].
- `out_id`  out  1  requester index that owns the result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, MUL, CONVERT, DONE.
- IDLE: the arbiter selects among asserted `reqN_valid`. `reqN_ready` is asserted combinationally for the winner only. On the handshake, operands are latched into `mult_m`/`mult_q`, `out_id` is latched, and the FSM goes to MUL.
- MUL: one cycle. `mult_p` is sampled into `out_bin` and the BCD shift register. The BCD digits are cleared and the bit counter is loaded with 2*WIDTH. Next state is CONVERT.
- CONVERT: one bit per cycle. Each BCD digit >= 5 has 3 added, then {bcd, bin_shift} shifts left by 1. The counter decrements. After 2*WIDTH iterations the FSM goes to DONE.
- DONE: `out_valid`=1. `out_bin`, `out_bcd` and `out_id` are held stable until `out_valid`&`out_ready`. The FSM then returns to IDLE; the earliest next grant is the following cycle.
- Requesters must hold valid and operands stable until ready. `reqN_ready` is 0 outside IDLE.
- `mult_m`/`mult_q` keep their last value outside MUL; the multiplier output is ignored except in MUL.
- Arbitration is round-robin by default (see Configuration). A `last_grant` register updates on each handshake.
- Reset values: FSM=IDLE, all ready/valid outputs 0, `mult_m`/`mult_q`/`out_bin`/`out_bcd`/`out_id`=0, `busy`=0, `last_grant`=1 so requester 0 wins the first tie.
- Reset asserted in any state aborts the transaction immediately. No `out_valid` is produced for it, and the requester is not re-acked.

## Timing
- Handshake at cycle T (IDLE), MUL at T+1, CONVERT at T+2 .. T+1+2*WIDTH, `out_valid` rises at T+2+2*WIDTH.
- For WIDTH=4 the latency is 10 cycles from handshake to `out_valid`.
- With `out_ready` held high, the minimum issue interval is 2*WIDTH+4 cycles.
- `out_ready` high before `out_valid` has no effect.
- The block has no combinational path from `out_ready` to any output except state transition next cycle.

## Configuration
- `MULT_SCHED_ROUND_ROBIN_EN` defined: round-robin arbitration. On simultaneous requests, the requester not granted last wins.
- Not defined: fixed priority, requester 0 always wins ties. The `last_grant` register is not implemented, and requester 1 may starve.

## Test plan
- Requester 0 sends m=15, q=12 with `out_ready`=1 -> `out_bin`=8'hB4, `out_bcd`=12'h180, `out_id`=0, `out_valid` exactly 10 cycles after handshake.
- m=15, q=15 then m=0, q=7 -> `out_bcd`=12'h225, then 12'h000; `out_bin` equals 225 and 0 respectively.
- Both requesters hold valid continuously, round-robin build -> grants alternate 0,1,0,1. Fixed-priority build -> all grants to 0.
- `out_ready` held low 5 cycles in DONE -> outputs stable, `busy`=1, `req1_ready` stays 0; the release returns the FSM to IDLE next cycle.
- `rst_n` pulsed low at CONVERT iteration 3 -> all outputs return to reset values asynchronously. After release, a fresh request completes normally with the correct result.
- Exhaustive sweep of all 256 operand pairs via requester 1 -> `out_bin`=m*q, and `out_bcd` decodes to the same value for every pair.

Source files
------------

// File: rtl/mult_bcd_scheduler.sv
// Shares one combinational multiplier between two requesters and converts the product to packed BCD.
// Define MULT_SCHED_ROUND_ROBIN_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mult_bcd_scheduler #(
  parameter int WIDTH      = 4,
  parameter int BCD_DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req0_valid,
  input  logic [WIDTH-1:0]          req0_m,
  input  logic [WIDTH-1:0]          req0_q,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [WIDTH-1:0]          req1_m,
  input  logic [WIDTH-1:0]          req1_q,
  output logic                      req1_ready,
  output logic [WIDTH-1:0]          mult_m,
  output logic [WIDTH-1:0]          mult_q,
  input  logic [2*WIDTH-1:0]        mult_p,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*WIDTH-1:0]        out_bin,
  output logic [4*BCD_DIGITS-1:0]   out_bcd,
  output logic                      out_id,
  output logic                      busy
);

  localparam int PW = 2 * WIDTH;
  localparam int BW = 4 * BCD_DIGITS;
  localparam int CW = $clog2(PW + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(PW);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_CONVERT, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WIDTH-1:0] r_mult_m;
  logic [WIDTH-1:0] r_mult_q;
  logic [PW-1:0]   r_out_bin;
  logic [PW-1:0]   r_shift;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_cnt;
  logic            r_out_id;
  logic            r_idle_gap;
  logic            w_sel1;
  logic            w_hs;
  logic [BW-1:0]   w_bcd_adj;

  // Double-dabble correction: any digit of 5 or more gets 3 added before the shift.
  function automatic logic [BW-1:0] f_add3(input logic [BW-1:0] bcd);
    logic [BW-1:0] res;
    res = bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) res[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
    return res;
  endfunction

`ifdef MULT_SCHED_ROUND_ROBIN_EN
  logic r_last_grant;

  // On a tie, the requester that was not granted last wins.
  assign w_sel1 = req1_valid & (~req0_valid | ~r_last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_last_grant <= 1'b1;
    else if (w_hs)  r_last_grant <= w_sel1;
  end
`else
  assign w_sel1 = req1_valid & ~req0_valid;
`endif

  assign w_hs      = req0_ready | req1_ready;
  assign w_bcd_adj = f_add3(r_bcd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_hs) w_next = S_MUL;
      S_MUL:     w_next = S_CONVERT;
      S_CONVERT: if (r_cnt == CNT_ONE) w_next = S_DONE;
      S_DONE:    if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // The first IDLE cycle after a completed result grants nobody.
  always_comb begin
    out_valid  = (r_state == S_DONE);
    busy       = (r_state != S_IDLE);
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (r_state == S_IDLE && !r_idle_gap) begin
      req0_ready = req0_valid & ~w_sel1;
      req1_ready = w_sel1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mult_m   <= '0;
      r_mult_q   <= '0;
      r_out_bin  <= '0;
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_out_id   <= 1'b0;
      r_idle_gap <= 1'b0;
    end else begin
      r_idle_gap <= (r_state == S_DONE) && out_ready;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_mult_m <= w_sel1 ? req1_m : req0_m;
            r_mult_q <= w_sel1 ? req1_q : req0_q;
            r_out_id <= w_sel1;
          end
        end
        S_MUL: begin
          r_out_bin <= mult_p;
          r_shift   <= mult_p;
          r_bcd     <= '0;
          r_cnt     <= CNT_INIT;
        end
        S_CONVERT: begin
          r_bcd   <= {w_bcd_adj[BW-2:0], r_shift[PW-1]};
          r_shift <= {r_shift[PW-2:0], 1'b0};
          r_cnt   <= r_cnt - CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign mult_m  = r_mult_m;
  assign mult_q  = r_mult_q;
  assign out_bin = r_out_bin;
  assign out_bcd = r_bcd;
  assign out_id  = r_out_id;

endmodule

// File: tb/tb_mult_bcd_scheduler.sv
// Directed-plus-random bench for mult_bcd_scheduler with a behavioural multiply/decimal reference.
module tb_mult_bcd_scheduler;
  localparam int WIDTH = 4;
  localparam int BCD_DIGITS = 3;
  localparam int PW = 2 * WIDTH;
  localparam int BW = 4 * BCD_DIGITS;
  localparam int LAT = 2 * WIDTH + 2;
  localparam int ISSUE = 2 * WIDTH + 4;
`ifdef MULT_SCHED_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [WIDTH-1:0] req0_m = '0, req0_q = '0, req1_m = '0, req1_q = '0;
  logic req0_ready, req1_ready;
  logic [WIDTH-1:0] mult_m, mult_q;
  logic [PW-1:0] mult_p;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [PW-1:0] out_bin;
  logic [BW-1:0] out_bcd;
  logic out_id, busy;

  int total = 0;
  int bad = 0;

  mult_bcd_scheduler #(.WIDTH(WIDTH), .BCD_DIGITS(BCD_DIGITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_m(req0_m), .req0_q(req0_q), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_m(req1_m), .req1_q(req1_q), .req1_ready(req1_ready),
    .mult_m(mult_m), .mult_q(mult_q), .mult_p(mult_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_bcd(out_bcd), .out_id(out_id), .busy(busy)
  );

  assign mult_p = mult_m * mult_q;

  always #5 clk = ~clk;

  // Decimal digits of v, least significant digit in the low nibble.
  function automatic logic [BW-1:0] ref_bcd(input int v);
    logic [BW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int who, input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] q,
                         input bit rdy_early, input string tag);
    int cyc;
    logic rdy;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    out_ready  = rdy_early;
    if (who == 1) begin req1_valid = 1'b1; req1_m = m; req1_q = q; end
    else          begin req0_valid = 1'b1; req0_m = m; req0_q = q; end
    #1;
    cyc = 0;
    rdy = (who == 1) ? req1_ready : req0_ready;
    while (!rdy && cyc < 50) begin
      tick();
      cyc++;
      rdy = (who == 1) ? req1_ready : req0_ready;
    end
    chk({tag, "_grant"}, {31'd0, rdy}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_m = 4'($urandom_range(0, 15));
    req1_q = 4'($urandom_range(0, 15));
    chk({tag, "_mult_m"}, {28'd0, mult_m}, {28'd0, m});
    chk({tag, "_mult_q"}, {28'd0, mult_q}, {28'd0, q});
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, LAT);
    chk({tag, "_bin"}, {24'd0, out_bin}, m * q);
    chk({tag, "_bcd"}, {20'd0, out_bcd}, {20'd0, ref_bcd(int'(m) * int'(q))});
    chk({tag, "_id"}, {31'd0, out_id}, who);
    out_ready = 1'b1;
    tick();
    chk({tag, "_release"}, {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc, win, exp_win, last, seen;
    logic [WIDTH-1:0] gm, gq;

    // Reset state
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_bin", {24'd0, out_bin}, 0);
    chk("rst_out_bcd", {20'd0, out_bcd}, 0);
    chk("rst_out_id", {31'd0, out_id}, 0);
    chk("rst_mult_m", {28'd0, mult_m}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {31'd0, busy}, 0);

    // Directed products
    run_txn(0, 4'd15, 4'd12, 1'b1, "m15q12");
    run_txn(1, 4'd15, 4'd15, 1'b0, "m15q15");
    run_txn(0, 4'd0, 4'd7, 1'b0, "m0q7");

    // Backpressure in DONE
    req1_valid = 1'b1; req1_m = 4'd9; req1_q = 4'd9;
    cyc = 0;
    while (!req1_ready && cyc < 50) begin tick(); cyc++; end
    chk("hold_grant", {31'd0, req1_ready}, 1);
    tick();
    req1_m = 4'd3; req1_q = 4'd4;
    cyc = 1;
    while (!out_valid && cyc < 50) begin tick(); cyc++; end
    chk("hold_latency", cyc, LAT);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, out_valid}, 1);
      chk("hold_busy", {31'd0, busy}, 1);
      chk("hold_req1_ready", {31'd0, req1_ready}, 0);
      chk("hold_bin", {24'd0, out_bin}, 81);
      chk("hold_bcd", {20'd0, out_bcd}, 32'h081);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("hold_rel_busy", {31'd0, busy}, 0);
    chk("hold_rel_valid", {31'd0, out_valid}, 0);
    chk("hold_gap_ready", {31'd0, req1_ready}, 0);
    out_ready = 1'b0;
    tick();
    chk("hold_next_ready", {31'd0, req1_ready}, 1);
    req1_valid = 1'b0;
    tick();

    // Asynchronous reset during conversion
    req1_valid = 1'b1; req1_m = 4'd13; req1_q = 4'd11;
    #1;
    cyc = 0;
    while (!req1_ready && cyc < 50) begin tick(); cyc++; end
    tick();
    req1_valid = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_bin", {24'd0, out_bin}, 0);
    chk("arst_bcd", {20'd0, out_bcd}, 0);
    chk("arst_id", {31'd0, out_id}, 0);
    chk("arst_mult_m", {28'd0, mult_m}, 0);
    chk("arst_mult_q", {28'd0, mult_q}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid || busy) seen++;
    end
    chk("arst_no_result", seen, 0);
    run_txn(1, 4'd13, 4'd11, 1'b0, "post_rst");

    // Contention: both requesters valid continuously
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    req0_valid = 1'b1; req0_m = 4'($urandom_range(0, 15)); req0_q = 4'($urandom_range(0, 15));
    req1_valid = 1'b1; req1_m = 4'($urandom_range(0, 15)); req1_q = 4'($urandom_range(0, 15));
    last = 1;
    cyc = 0;
    for (int g = 0; g < 4; g++) begin
      while (!(req0_ready || req1_ready) && cyc < 60) begin tick(); cyc++; end
      if (g > 0) chk("arb_issue_gap", cyc, ISSUE);
      win = req1_ready ? 1 : 0;
      exp_win = RR ? ((last == 1) ? 0 : 1) : 0;
      chk("arb_winner", win, exp_win);
      gm = (win == 1) ? req1_m : req0_m;
      gq = (win == 1) ? req1_q : req0_q;
      tick();
      last = win;
      if (win == 1) begin req1_m = 4'($urandom_range(0, 15)); req1_q = 4'($urandom_range(0, 15)); end
      else          begin req0_m = 4'($urandom_range(0, 15)); req0_q = 4'($urandom_range(0, 15)); end
      cyc = 1;
      while (!out_valid && cyc < 60) begin tick(); cyc++; end
      chk("arb_latency", cyc, LAT);
      chk("arb_bin", {24'd0, out_bin}, gm * gq);
      chk("arb_bcd", {20'd0, out_bcd}, {20'd0, ref_bcd(int'(gm) * int'(gq))});
      chk("arb_id", {31'd0, out_id}, win);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0;

    // Random single-requester traffic
    for (int i = 0; i < 12; i++) begin
      run_txn(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), "rand");
    end

    // Exhaustive operand sweep through requester 1
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_txn(1, 4'(a), 4'(b), 1'b0, "sweep");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
